// File: rtl/event_rate_meter_pkg.sv
// Shared constants and helpers for the event-rate meter (on-board FPS measurement).
// Holds the 3.3 MHz board-clock calibration constant, the default count width used
// for frame rates, the gate-action encoding shared by top and channels, and a
// helper that locates one channel's slice inside the packed RATE_OUT bus.
package event_rate_meter_pkg;

    // Board clock cycles in one calibrated second (nominal 3.3 MHz oscillator).
    localparam int unsigned CLOCKS_PER_SEC_3P3 = 3287000;

    // Default per-channel count width: 8 bits covers any realistic frame rate.
    localparam int unsigned FPS_CNT_W = 8;

    // What the gate logic does on a given cycle (RST is handled separately, above all).
    typedef enum logic [1:0] {
        GATE_RUN   = 2'd0,  // window in progress, events accumulate
        GATE_END   = 2'd1,  // terminal count: latch counts, start new window
        GATE_CLEAR = 2'd2   // restart window, drop partial counts, no latch
    } gate_act_e;

    // LSB position of channel ch inside RATE_OUT.
    function automatic int unsigned rate_lsb(input int unsigned ch, input int unsigned cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/event_rate_meter_rate_channel.sv
// One event channel of the rate meter: optional 2-FF synchroniser, rising-edge
// detect, saturating per-window accumulator with overflow flag, and the latched
// count/overflow registers that update on the window-end strobe.
// Build option: EVENT_RATE_METER_SYNC_EN inserts the synchroniser (async sources);
// without it the event input must already be synchronous to the clock.
module event_rate_meter_rate_channel
    import event_rate_meter_pkg::*;
#(
    parameter int unsigned CNT_W = FPS_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_event,
    input  logic             i_tc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_rate,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_level;
    logic             w_event;
    logic             w_at_max;
    logic [CNT_W-1:0] w_sat_sum;

    logic             r_hist;
    logic [CNT_W-1:0] r_acc;
    logic             r_acc_ovf;
    logic [CNT_W-1:0] r_rate;
    logic             r_ovf;

`ifdef EVENT_RATE_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-stage synchroniser; resets high so a line already high is not an event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_event;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level = r_sync2;
`else
    assign w_level = i_event;
`endif

    // Edge-detect history; follows the level every cycle, even during CLEAR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= w_level;
        end
    end

    assign w_event  = w_level & ~r_hist;
    assign w_at_max = (r_acc == CNT_MAX);

    // Accumulator value including this cycle's event, pinned at full scale.
    always_comb begin
        w_sat_sum = r_acc;
        if (w_event && !w_at_max) begin
            w_sat_sum = r_acc + CNT_W'(1);
        end
    end

    // Window accumulation and end-of-window latch; CLEAR beats the window end.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
            r_rate    <= '0;
            r_ovf     <= 1'b0;
        end else if (i_clear) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (i_tc) begin
            // An event on the window-end cycle still belongs to the closing window.
            r_rate    <= w_sat_sum;
            r_ovf     <= r_acc_ovf | (w_event & w_at_max);
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_event) begin
            r_acc <= w_sat_sum;
            if (w_at_max) begin
                r_acc_ovf <= 1'b1;
            end
        end
    end

    assign o_rate = r_rate;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/event_rate_meter.sv
// Multi-channel event-rate meter: counts rising edges on each EVENT_IN bit over a
// gate window of CLOCKS_PER_GATE clocks, latches the per-channel counts at window
// end with a one-cycle RATE_VALID strobe, and toggles HEARTBEAT once per window.
// Build option: EVENT_RATE_METER_SYNC_EN adds a 2-FF synchroniser per input
// (handled inside each channel), raising event-to-count latency from 1 to 3 cycles.
module event_rate_meter
    import event_rate_meter_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_GATE = CLOCKS_PER_SEC_3P3,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned CNT_W           = FPS_CNT_W,
    parameter int unsigned GATE_W          = 32
) (
    input  logic                      CLK_3P3_MHZ,
    input  logic                      RST,
    input  logic [NUM_CH-1:0]         EVENT_IN,
    input  logic                      CLEAR,
    output logic [NUM_CH*CNT_W-1:0]   RATE_OUT,
    output logic                      RATE_VALID,
    output logic [NUM_CH-1:0]         OVERFLOW,
    output logic                      HEARTBEAT
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLOCKS_PER_GATE - 1);

    logic              r_gate;
    logic [GATE_W-1:0] r_gate_cnt;
    logic              r_valid;
    logic              r_heartbeat;

    logic              w_gate_tc;
    gate_act_e         w_gate_act;
    logic              w_tc;
    logic              w_clr;

    assign w_gate_tc = (r_gate_cnt == GATE_LAST);

    // Resolve CLEAR against terminal count; CLEAR suppresses the window end.
    always_comb begin
        w_gate_act = GATE_RUN;
        if (CLEAR) begin
            w_gate_act = GATE_CLEAR;
        end else if (w_gate_tc) begin
            w_gate_act = GATE_END;
        end
    end

    assign w_tc  = (w_gate_act == GATE_END);
    assign w_clr = (w_gate_act == GATE_CLEAR);

    // Gate counter: 0..CLOCKS_PER_GATE-1, restarted by window end or CLEAR.
    always_ff @(posedge CLK_3P3_MHZ) begin
        if (RST) begin
            r_gate_cnt <= '0;
        end else if (w_clr || w_tc) begin
            r_gate_cnt <= '0;
        end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        end
    end

    // Valid strobe lands the cycle after window end, together with new RATE_OUT.
    always_ff @(posedge CLK_3P3_MHZ) begin
        if (RST) begin
            r_valid     <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            r_valid <= w_tc;
            if (w_tc) begin
                r_heartbeat <= ~r_heartbeat;
            end
        end
    end

    // Registered copy of the window-end strobe kept for probing the gate phase.
    always_ff @(posedge CLK_3P3_MHZ) begin
        if (RST) begin
            r_gate <= 1'b0;
        end else begin
            r_gate <= w_tc;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        localparam int unsigned LSB = rate_lsb(g, CNT_W);

        event_rate_meter_rate_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk   (CLK_3P3_MHZ),
            .i_rst   (RST),
            .i_event (EVENT_IN[g]),
            .i_tc    (w_tc),
            .i_clear (w_clr),
            .o_rate  (RATE_OUT[LSB +: CNT_W]),
            .o_ovf   (OVERFLOW[g])
        );
    end

    assign RATE_VALID = r_valid & r_gate;
    assign HEARTBEAT  = r_heartbeat;

endmodule

// File: tb/tb_event_rate_meter.sv
// Bench for event_rate_meter with a 100-clock gate, two channels, 4-bit counts.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// A window-level model (raw event counts, clipped at window end) is compared every
// cycle, and a table of hand-computed values pins the key cycles of each scenario.
module tb_event_rate_meter;

    localparam int G      = 100;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
    localparam int MAX    = (1 << CNT_W) - 1;
`ifdef EVENT_RATE_METER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       ev_in = '0;
    logic                    clear = 1'b0;
    logic [NUM_CH*CNT_W-1:0] rate_out;
    logic                    rate_valid;
    logic [NUM_CH-1:0]       overflow;
    logic                    heartbeat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    event_rate_meter #(
        .CLOCKS_PER_GATE (G),
        .NUM_CH          (NUM_CH),
        .CNT_W           (CNT_W),
        .GATE_W          (32)
    ) dut (
        .CLK_3P3_MHZ (clk),
        .RST         (rst),
        .EVENT_IN    (ev_in),
        .CLEAR       (clear),
        .RATE_OUT    (rate_out),
        .RATE_VALID  (rate_valid),
        .OVERFLOW    (overflow),
        .HEARTBEAT   (heartbeat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic                    m_ready = 1'b0;
    int                      m_pos;
    int                      m_cnt[NUM_CH];
    logic [NUM_CH-1:0]       m_prev;
    logic [NUM_CH-1:0]       m_pipe[$];
    logic [NUM_CH*CNT_W-1:0] m_rate;
    logic [NUM_CH-1:0]       m_ovf;
    logic                    m_valid;
    logic                    m_hb;

    always @(posedge clk) begin : model_blk
        logic [NUM_CH-1:0] eff;
        logic [NUM_CH-1:0] ev;
        if (rst) begin
            m_ready = 1'b1;
            m_pos   = 0;
            for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
            m_prev  = '1;
            m_pipe.delete();
            for (int k = 0; k < D; k++) m_pipe.push_back('1);
            m_rate  = '0;
            m_ovf   = '0;
            m_valid = 1'b0;
            m_hb    = 1'b0;
        end else begin
            if (D == 0) begin
                eff = ev_in;
            end else begin
                eff = m_pipe.pop_front();
                m_pipe.push_back(ev_in);
            end
            ev      = eff & ~m_prev;
            m_prev  = eff;
            m_valid = 1'b0;
            if (clear) begin
                m_pos = 0;
                for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] += int'(ev[ch]);
                if (m_pos == G - 1) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        m_rate[ch*CNT_W +: CNT_W] = CNT_W'((m_cnt[ch] > MAX) ? MAX : m_cnt[ch]);
                        m_ovf[ch] = (m_cnt[ch] > MAX);
                        m_cnt[ch] = 0;
                    end
                    m_valid = 1'b1;
                    m_hb    = ~m_hb;
                    m_pos   = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // Every-cycle comparison against the model once reset has been applied.
    always @(negedge clk) begin
        if (m_ready) begin
            check("model_rate",  32'(rate_out),   32'(m_rate));
            check("model_valid", 32'(rate_valid), 32'(m_valid));
            check("model_ovf",   32'(overflow),   32'(m_ovf));
            check("model_hb",    32'(heartbeat),  32'(m_hb));
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic ev_pulse4(input int c, input int first, input int n);
        return (c >= first) && (c <= first + 4 * (n - 1)) && ((c - first) % 4 == 0);
    endfunction

    task automatic stim(input int p, input int c);
        logic [NUM_CH-1:0] ev;
        logic              clr;
        logic              r;
        ev  = '0;
        clr = 1'b0;
        r   = 1'b0;
        case (p)
            2: begin
                ev[0] = (c >= 10 && c <= 50 && c % 10 == 0) || (c >= 199 - D && c < 205 - D);
                ev[1] = (c < 150) || (c >= 200 - D);
            end
            3: begin
                ev[1] = ev_pulse4(c, 10, 20) || c == 110 || c == 120 || c == 130;
                ev[0] = ev_pulse4(c, 210, 15);
            end
            4: begin
                ev[0] = (c == 10 || c == 20 || c == 30 || c == 40 || c == 60 || c == 70);
                ev[1] = (c == 160 || c == 165);
                clr   = (c == 50);
                r     = (c == 170);
            end
            5: begin
                ev[0] = (c == 30 || c == 150);
                clr   = (c == 99);
            end
            default: ;
        endcase
        ev_in = ev;
        clear = clr;
        rst   = r;
    endtask

    task automatic pin(input int p, input int c, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        check($sformatf("p%0d_c%0d_%s", p, c, what), act, exp);
    endtask

    // Hand-computed values at the interesting cycles of each scenario.
    task automatic pins(input int p, input int c);
        case ({p[7:0], c[15:0]})
            {8'd1, 16'd50}:  begin pin(p, c, "rate", 32'(rate_out), 32'h00);
                                   pin(p, c, "valid", 32'(rate_valid), 0);
                                   pin(p, c, "hb", 32'(heartbeat), 0); end
            {8'd1, 16'd100}: begin pin(p, c, "valid", 32'(rate_valid), 1);
                                   pin(p, c, "rate", 32'(rate_out), 32'h00);
                                   pin(p, c, "hb", 32'(heartbeat), 1); end
            {8'd1, 16'd101}: pin(p, c, "valid", 32'(rate_valid), 0);
            {8'd2, 16'd100}: begin pin(p, c, "rate", 32'(rate_out), 32'h05);
                                   pin(p, c, "ovf", 32'(overflow), 0);
                                   pin(p, c, "valid", 32'(rate_valid), 1); end
            {8'd2, 16'd200}: pin(p, c, "rate", 32'(rate_out), 32'h01);
            {8'd2, 16'd300}: begin pin(p, c, "rate", 32'(rate_out), 32'h10);
                                   pin(p, c, "hb", 32'(heartbeat), 1); end
            {8'd3, 16'd100}: begin pin(p, c, "rate", 32'(rate_out), 32'hF0);
                                   pin(p, c, "ovf", 32'(overflow), 32'h2); end
            {8'd3, 16'd200}: begin pin(p, c, "rate", 32'(rate_out), 32'h30);
                                   pin(p, c, "ovf", 32'(overflow), 0);
                                   pin(p, c, "hb", 32'(heartbeat), 0); end
            {8'd3, 16'd300}: begin pin(p, c, "rate", 32'(rate_out), 32'h0F);
                                   pin(p, c, "ovf", 32'(overflow), 0); end
            {8'd4, 16'd100}: begin pin(p, c, "valid", 32'(rate_valid), 0);
                                   pin(p, c, "hb", 32'(heartbeat), 0); end
            {8'd4, 16'd151}: begin pin(p, c, "valid", 32'(rate_valid), 1);
                                   pin(p, c, "rate", 32'(rate_out), 32'h02);
                                   pin(p, c, "hb", 32'(heartbeat), 1); end
            {8'd4, 16'd171}: begin pin(p, c, "rate", 32'(rate_out), 32'h00);
                                   pin(p, c, "hb", 32'(heartbeat), 0); end
            {8'd4, 16'd270}: pin(p, c, "valid", 32'(rate_valid), 0);
            {8'd4, 16'd271}: begin pin(p, c, "valid", 32'(rate_valid), 1);
                                   pin(p, c, "hb", 32'(heartbeat), 1); end
            {8'd5, 16'd100}: begin pin(p, c, "valid", 32'(rate_valid), 0);
                                   pin(p, c, "hb", 32'(heartbeat), 0); end
            {8'd5, 16'd200}: begin pin(p, c, "valid", 32'(rate_valid), 1);
                                   pin(p, c, "rate", 32'(rate_out), 32'h01);
                                   pin(p, c, "hb", 32'(heartbeat), 1); end
            default: ;
        endcase
    endtask

    // Reset for three clocks with the given input levels, then run the scenario.
    // At loop index c the outputs shown are those of cycle c, and the inputs set
    // here are sampled on edge c (edge 0 = first edge with reset low).
    task automatic run_phase(input int p, input logic [NUM_CH-1:0] ev_init, input int n);
        @(negedge clk);
        rst   = 1'b1;
        clear = 1'b0;
        ev_in = ev_init;
        repeat (3) @(negedge clk);
        for (int c = 0; c < n; c++) begin
            stim(p, c);
            pins(p, c);
            @(negedge clk);
        end
    endtask

    initial begin
        run_phase(1, 2'b00, 102);
        run_phase(2, 2'b10, 302);
        run_phase(3, 2'b00, 302);
        run_phase(4, 2'b00, 273);
        run_phase(5, 2'b00, 202);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
